// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default latencies
// (also used by decode/stall logic) and FSM state type.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_BUSY = 2'd2
    } md_state_t;

    function automatic int md_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO; long ops hold busy for a fixed latency and
// commit their result on the edge where busy falls.
//
// state        | meaning
// ST_IDLE      | no long op in flight, accepts start (mthi/mtlo write immediately)
// ST_MUL_BUSY  | mult/multu in flight, counter runs down to 0, commit at 0
// ST_DIV_BUSY  | div/divu in flight, counter runs down to 0, commit at 0
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = md_max(MULT_CYCLES, DIV_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    md_op_t           op_in;
    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept, commit, wr_hi, wr_lo;

    md_op_t           pend_op;
    logic [31:0]      pend_a, pend_b;
    logic [31:0]      res_hi, res_lo;
    logic             res_we;

    logic signed [63:0] sa64, sb64, prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sa32, sb32;

    assign op_in = md_op_t'(md_op);
    assign busy  = (state != ST_IDLE);
    assign wr_hi = (state == ST_IDLE) && start && (op_in == MD_MTHI);
    assign wr_lo = (state == ST_IDLE) && start && (op_in == MD_MTLO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op_in)
                        MD_MULT, MD_MULTU: begin
                            state_nxt = ST_MUL_BUSY;
                            accept    = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_nxt = ST_DIV_BUSY;
                            accept    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_BUSY, ST_DIV_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sa64   = {{32{pend_a[31]}}, pend_a};
    assign sb64   = {{32{pend_b[31]}}, pend_b};
    assign prod_s = sa64 * sb64;
    assign prod_u = {32'd0, pend_a} * {32'd0, pend_b};
    assign sa32   = pend_a;
    assign sb32   = pend_b;

    // Divide by zero leaves res_we low so HI/LO keep their old contents.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b0;
        case (pend_op)
            MD_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_we           = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_we           = 1'b1;
            end
            MD_DIV: begin
                if (pend_b != '0) begin
                    res_we = 1'b1;
                    if (pend_a == 32'h8000_0000 && pend_b == 32'hFFFF_FFFF) begin
                        res_lo = 32'h8000_0000;
                        res_hi = '0;
                    end else begin
                        res_lo = sa32 / sb32;
                        res_hi = sa32 % sb32;
                    end
                end
            end
            MD_DIVU: begin
                if (pend_b != '0) begin
                    res_we = 1'b1;
                    res_lo = pend_a / pend_b;
                    res_hi = pend_a % pend_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_op <= MD_NONE;
            pend_a  <= '0;
            pend_b  <= '0;
        end else begin
            if (accept) begin
                pend_op <= op_in;
                pend_a  <= a;
                pend_b  <= b;
                cnt     <= (state_nxt == ST_MUL_BUSY) ? CNT_W'(MULT_CYCLES - 1)
                                                      : CNT_W'(DIV_CYCLES - 1);
            end else if (busy && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                pend_op <= MD_NONE;
                if (res_we) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table of ops with expected HI/LO and busy
// length, plus sequences for start-while-busy and reset during a divide.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one start pulse; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob);
        start = 1'b1;
        md_op = op;
        a     = oa;
        b     = ob;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        a     = '0;
        b     = '0;
    endtask

    // Counts busy cycles (bounded) and checks hi/lo hold their old values meanwhile.
    task automatic wait_done(input string name, input logic [31:0] old_hi, input logic [31:0] old_lo,
                             output int cyc);
        logic hold_bad;
        hold_bad = 1'b0;
        cyc      = 0;
        while (busy === 1'b1 && cyc < 64) begin
            if (hi !== old_hi || lo !== old_lo) hold_bad = 1'b1;
            cyc++;
            @(negedge clk);
        end
        check({name, "_hold"}, {31'd0, hold_bad}, 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] exp_hi, exp_lo;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd4, 32'd7,         32'd2,         32'd1,         32'd3,         10};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
        vecs[5]  = '{3'd5, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'h8000_0000, 0};
        vecs[6]  = '{3'd6, 32'hCAFE_F00D, 32'd9,         32'h1234_5678, 32'hCAFE_F00D, 0};
        vecs[7]  = '{3'd4, 32'd5,         32'd0,         32'h1234_5678, 32'hCAFE_F00D, 10};
        vecs[8]  = '{3'd3, 32'd100,       32'd0,         32'h1234_5678, 32'hCAFE_F00D, 10};
        vecs[9]  = '{3'd7, 32'd1,         32'd1,         32'h1234_5678, 32'hCAFE_F00D, 0};
        vecs[10] = '{3'd0, 32'd1,         32'd1,         32'h1234_5678, 32'hCAFE_F00D, 0};
        vecs[11] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[12] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         5};
        vecs[13] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};

        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        exp_hi = 32'd0;
        exp_lo = 32'd0;
        // Ops run back to back: each issue starts on the first non-busy cycle.
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("row%0d", i), exp_hi, exp_lo, cyc);
            check($sformatf("row%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("row%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("row%0d_lo", i), lo, vecs[i].lo);
            exp_hi = vecs[i].hi;
            exp_lo = vecs[i].lo;
        end

        // mtlo pulsed during a mult must be ignored and must not shift the commit.
        issue(3'd1, 32'd3, 32'd5);
        start = 1'b1;
        md_op = 3'd6;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        a     = '0;
        wait_done("ignore", exp_hi, exp_lo, cyc);
        check("ignore_busy_cycles", 32'(cyc + 1), 32'd5);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd15);
        @(negedge clk);
        check("ignore_lo_later", lo, 32'd15);

        // Reset during the 4th busy cycle of a div aborts it with no later commit.
        issue(3'd5, 32'hAAAA_5555, 32'd0);
        check("mthi_pre_reset", hi, 32'hAAAA_5555);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);
        issue(3'd6, 32'd5, 32'd0);
        check("post_reset_mtlo_lo", lo, 32'd5);
        check("post_reset_mtlo_hi", hi, 32'd0);
        check("post_reset_mtlo_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
